// File: rtl/pitch_table_writer.sv
// Stores one phase delta per pitch into the 16-bit pitch RAM as a low/high word pair,
// optionally reading both words back and flagging a mismatch on completion.
module pitch_table_writer #(
  parameter int PITCH_WIDTH = 6,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter bit VERIFY      = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [PITCH_WIDTH-1:0]  i_pitch,
  input  logic [2*DATA_WIDTH-1:0] i_phase_delta,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  output logic [ADDR_WIDTH-1:0]   o_ram_addr,
  output logic [DATA_WIDTH-1:0]   o_ram_wdata,
  output logic                    o_ram_we,
  input  logic [DATA_WIDTH-1:0]   i_ram_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_LO = 3'd1,
    WR_HI = 3'd2,
    RD_LO = 3'd3,
    RD_HI = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic [2*DATA_WIDTH-1:0] pd_r;
  logic [DATA_WIDTH-1:0]   rb_lo_r;
  logic                    err_r;
  logic                    accept_s;
  logic [ADDR_WIDTH-1:0]   base_in_s;
  logic [ADDR_WIDTH-1:0]   base_hi_s;

  function automatic logic word_pair_mismatch(input logic [2*DATA_WIDTH-1:0] readback,
                                              input logic [2*DATA_WIDTH-1:0] expected);
    return (readback != expected);
  endfunction

  assign accept_s  = (state_r == IDLE) && i_valid;
  assign base_in_s = {{(ADDR_WIDTH-PITCH_WIDTH-1){1'b0}}, i_pitch, 1'b0};
  // base is always even, so the high word simply sets bit 0 and can never carry.
  assign base_hi_s = {base_r[ADDR_WIDTH-1:1], 1'b1};

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request latch, low-word readback capture and mismatch flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      base_r  <= '0;
      pd_r    <= '0;
      rb_lo_r <= '0;
      err_r   <= 1'b0;
    end else if (accept_s) begin
      base_r  <= base_in_s;
      pd_r    <= i_phase_delta;
      err_r   <= 1'b0;
    end else if (state_r == RD_HI) begin
      rb_lo_r <= i_ram_rdata;
    end else if (state_r == CHECK) begin
      err_r   <= word_pair_mismatch({i_ram_rdata, rb_lo_r}, pd_r);
    end
  end

  // Next-state selection and RAM/handshake outputs.
  always_comb begin
    state_next_s = state_r;
    o_ready      = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    o_error      = 1'b0;
    o_ram_addr   = '0;
    o_ram_wdata  = '0;
    o_ram_we     = 1'b0;
    case (state_r)
      IDLE: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
        if (i_valid) begin
          state_next_s = WR_LO;
        end else begin
          state_next_s = IDLE;
        end
      end
      WR_LO: begin
        o_ram_addr   = base_r;
        o_ram_wdata  = pd_r[DATA_WIDTH-1:0];
        o_ram_we     = 1'b1;
        state_next_s = WR_HI;
      end
      WR_HI: begin
        o_ram_addr  = base_hi_s;
        o_ram_wdata = pd_r[2*DATA_WIDTH-1:DATA_WIDTH];
        o_ram_we    = 1'b1;
        if (VERIFY) begin
          state_next_s = RD_LO;
        end else begin
          state_next_s = DONE;
        end
      end
      RD_LO: begin
        o_ram_addr   = base_r;
        state_next_s = RD_HI;
      end
      RD_HI: begin
        o_ram_addr   = base_hi_s;
        state_next_s = CHECK;
      end
      CHECK: begin
        state_next_s = DONE;
      end
      DONE: begin
        o_done       = 1'b1;
        o_error      = err_r;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pitch_table_writer.sv
// Directed bench for pitch_table_writer: a verifying instance against a RAM model with one
// corrupted word, plus a write-only instance, with hand-computed expectations.
module tb_pitch_table_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, ready, busy, done, error, we;
  logic [5:0]  pitch;
  logic [31:0] pd;
  logic [7:0]  ram_addr;
  logic [15:0] wdata, rdata;

  logic        valid2, ready2, busy2, done2, error2, we2;
  logic [5:0]  pitch2;
  logic [31:0] pd2;
  logic [7:0]  ram_addr2;
  logic [15:0] wdata2, rdata2;

  logic [15:0] mem  [0:255];
  logic [15:0] mem2 [0:255];
  logic [7:0]  log_addr[$];
  logic [15:0] log_data[$];
  logic [7:0]  log2_addr[$];
  logic [15:0] log2_data[$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  always #5 clk = ~clk;

  pitch_table_writer #(.PITCH_WIDTH(6), .ADDR_WIDTH(8), .DATA_WIDTH(16), .VERIFY(1'b1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready), .i_pitch(pitch),
    .i_phase_delta(pd), .o_busy(busy), .o_done(done), .o_error(error),
    .o_ram_addr(ram_addr), .o_ram_wdata(wdata), .o_ram_we(we), .i_ram_rdata(rdata)
  );

  pitch_table_writer #(.PITCH_WIDTH(6), .ADDR_WIDTH(8), .DATA_WIDTH(16), .VERIFY(1'b0)) u_wo (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid2), .o_ready(ready2), .i_pitch(pitch2),
    .i_phase_delta(pd2), .o_busy(busy2), .o_done(done2), .o_error(error2),
    .o_ram_addr(ram_addr2), .o_ram_wdata(wdata2), .o_ram_we(we2), .i_ram_rdata(rdata2)
  );

  // RAM model with one-cycle read latency; address 21 always reads back corrupted.
  always @(posedge clk) begin
    if (we) begin
      mem[ram_addr] <= wdata;
      log_addr.push_back(ram_addr);
      log_data.push_back(wdata);
    end
    rdata <= (ram_addr == 8'd21) ? 16'hBEEF : mem[ram_addr];
  end

  // Clean RAM model for the write-only instance.
  always @(posedge clk) begin
    if (we2) begin
      mem2[ram_addr2] <= wdata2;
      log2_addr.push_back(ram_addr2);
      log2_data.push_back(wdata2);
    end
    rdata2 <= mem2[ram_addr2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One request on the verifying instance, checked cycle by cycle from the accept edge.
  task automatic run_req(input logic [5:0] p, input logic [31:0] d, input logic exp_err,
                         input logic hold_valid);
    logic [7:0] b;
    b = {1'b0, p, 1'b0};
    valid = 1'b1;
    pitch = p;
    pd    = d;
    tick;
    valid = hold_valid;
    chk("wrlo_addr", ram_addr, b);
    chk("wrlo_data", wdata, d[15:0]);
    chk("wrlo_we", we, 1'b1);
    chk("c1_busy", busy, 1'b1);
    chk("c1_ready", ready, 1'b0);
    tick;
    chk("wrhi_addr", ram_addr, b + 8'd1);
    chk("wrhi_data", wdata, d[31:16]);
    chk("wrhi_we", we, 1'b1);
    tick;
    chk("rdlo_addr", ram_addr, b);
    chk("rdlo_we", we, 1'b0);
    chk("c3_ready", ready, 1'b0);
    tick;
    chk("rdhi_addr", ram_addr, b + 8'd1);
    chk("rdhi_we", we, 1'b0);
    tick;
    chk("check_addr", ram_addr, 8'd0);
    chk("c5_done", done, 1'b0);
    tick;
    chk("c6_done", done, 1'b1);
    chk("c6_error", error, exp_err);
    chk("c6_ready", ready, 1'b0);
    tick;
    chk("c7_ready", ready, 1'b1);
    chk("c7_done", done, 1'b0);
    chk("c7_busy", busy, 1'b0);
    chk("c7_error", error, 1'b0);
  endtask

  logic [7:0]  exp_a [17];
  logic [15:0] exp_d [17];

  initial begin
    exp_a = '{8'd10, 8'd11, 8'd0, 8'd1, 8'd126, 8'd127, 8'd20, 8'd21, 8'd14, 8'd15,
              8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd18};
    exp_d = '{16'h5678, 16'h1234, 16'h5A5A, 16'hA5A5, 16'hFFFF, 16'h0000, 16'h0001, 16'hCAFE,
              16'hF00D, 16'h0BAD, 16'h2222, 16'h1111, 16'h4444, 16'h3333, 16'h6666, 16'h5555,
              16'h0009};
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 16'h0000;
      mem2[i] = 16'h0000;
    end
    rst_n = 1'b0; valid = 1'b0; pitch = 6'd0; pd = 32'd0;
    valid2 = 1'b0; pitch2 = 6'd0; pd2 = 32'd0;
    #12;
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_addr", ram_addr, 8'd0);
    chk("rst_wdata", wdata, 16'd0);
    chk("rst_ready2", ready2, 1'b1);
    tick;
    rst_n = 1'b1;
    tick;

    run_req(6'd5,  32'h12345678, 1'b0, 1'b0);
    run_req(6'd0,  32'hA5A55A5A, 1'b0, 1'b0);
    run_req(6'd63, 32'h0000FFFF, 1'b0, 1'b0);
    run_req(6'd10, 32'hCAFE0001, 1'b1, 1'b0);
    run_req(6'd7,  32'h0BADF00D, 1'b0, 1'b0);

    // Back-to-back with valid held high: accepts land exactly 7 cycles apart.
    run_req(6'd1, 32'h11112222, 1'b0, 1'b1);
    run_req(6'd2, 32'h33334444, 1'b0, 1'b1);
    run_req(6'd3, 32'h55556666, 1'b0, 1'b0);
    tick;
    chk("b2b_no_extra", busy, 1'b0);

    valid2 = 1'b1; pitch2 = 6'd2; pd2 = 32'hFFFF0000;
    tick;
    valid2 = 1'b0;
    chk("wo_lo_addr", ram_addr2, 8'd4);
    chk("wo_lo_data", wdata2, 16'h0000);
    chk("wo_lo_we", we2, 1'b1);
    tick;
    chk("wo_hi_addr", ram_addr2, 8'd5);
    chk("wo_hi_data", wdata2, 16'hFFFF);
    chk("wo_hi_we", we2, 1'b1);
    tick;
    chk("wo_done", done2, 1'b1);
    chk("wo_error", error2, 1'b0);
    chk("wo_done_we", we2, 1'b0);
    tick;
    chk("wo_ready", ready2, 1'b1);
    chk("wo_done_off", done2, 1'b0);
    chk("wo_log_len", log2_addr.size(), 2);
    if (log2_addr.size() == 2) begin
      chk("wo_log_a0", log2_addr[0], 8'd4);
      chk("wo_log_a1", log2_addr[1], 8'd5);
      chk("wo_log_d1", log2_data[1], 16'hFFFF);
    end

    // Reset while in WR_HI: write enable must drop at once and no done follows.
    valid = 1'b1; pitch = 6'd9; pd = 32'hDEAD0009;
    tick;
    valid = 1'b0;
    chk("rstmid_lo_addr", ram_addr, 8'd18);
    tick;
    chk("rstmid_hi_we", we, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_we", we, 1'b0);
    chk("rstmid_addr", ram_addr, 8'd0);
    chk("rstmid_ready", ready, 1'b1);
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("rstmid_no_done", done, 1'b0);
    end
    chk("rstmid_idle", ready, 1'b1);

    chk("log_len", log_addr.size(), 17);
    for (int i = 0; i < 17; i++) begin
      if (i < log_addr.size()) begin
        chk($sformatf("log_addr%0d", i), log_addr[i], exp_a[i]);
        chk($sformatf("log_data%0d", i), log_data[i], exp_d[i]);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
